// File: rtl/cb_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cb_cfg_pkg
// Shared definitions for the parametrised connection block: the configuration
// chain FSM state type and the helper functions that size the frame and locate
// each routing field inside the active configuration register.
//
// Frame layout (LSB first):
//   bit 2j              in-select for track j
//   bit 2j+1            out-select for track j
//   [2W + k*SEL_W +: SEL_W]  track select for CLB input k
//   bit CFG_BITS-1      even-parity bit (not used by routing)
// -----------------------------------------------------------------------------
package cb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // nothing shifted since the last commit or reset
        LOAD = 2'd1,   // partial or exactly complete frame in the shadow
        OVER = 2'd2    // more bits than a frame were shifted
    } chain_state_t;

    // Width of one CLB-input select field; never narrower than one bit.
    function automatic int sel_w(input int w);
        int s;
        s = $clog2(2 * w);
        return (s < 1) ? 1 : s;
    endfunction

    // Full frame length including the parity bit.
    function automatic int cfg_bits(input int w, input int k);
        return 2 * w + k * sel_w(w) + 1;
    endfunction

    function automatic int in_sel_bit(input int j);
        return 2 * j;
    endfunction

    function automatic int out_sel_bit(input int j);
        return 2 * j + 1;
    endfunction

    function automatic int clb_sel_lsb(input int w, input int k);
        return 2 * w + k * sel_w(w);
    endfunction

    function automatic int parity_bit(input int w, input int k);
        return cfg_bits(w, k) - 1;
    endfunction

endpackage

// File: rtl/cb_cfg_chain.sv
// -----------------------------------------------------------------------------
// cb_cfg_chain
// Serial configuration chain with a shadow register, a saturating frame bit
// counter, an even-parity check and an atomic commit into the active register.
// The active register only changes on an accepted commit, so anything decoded
// from it stays stable while a new frame is shifted in.
//
// Ports:
//   prog_clk     configuration clock
//   rst          synchronous, active-low reset
//   prog_in      serial configuration data
//   prog_en      shift enable
//   prog_commit  commit request (ignored while prog_en=1)
//   active       committed configuration
//   cfg_valid    active holds an accepted frame
//   cfg_error    last commit was rejected
//   prog_out     chain output (shadow[0])
//   bit_cnt      bits shifted since last commit/reset, saturates at CFG_BITS+1
// -----------------------------------------------------------------------------
module cb_cfg_chain
    import cb_cfg_pkg::*;
#(
    parameter  int CFG_BITS = 21,
    localparam int CNT_W    = $clog2(CFG_BITS + 2)
) (
    input  logic                prog_clk,
    input  logic                rst,
    input  logic                prog_in,
    input  logic                prog_en,
    input  logic                prog_commit,
    output logic [CFG_BITS-1:0] active,
    output logic                cfg_valid,
    output logic                cfg_error,
    output logic                prog_out,
    output logic [CNT_W-1:0]    bit_cnt
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CFG_BITS + 1);

    chain_state_t        state;
    chain_state_t        state_nxt;
    logic [CFG_BITS-1:0] shadow;
    logic                shift_req;
    logic                commit_req;
    logic                accept;
    logic                reject;

    // Shifting has priority: a commit coincident with a shift is dropped.
    assign shift_req  = prog_en;
    assign commit_req = prog_commit & ~prog_en;
    assign prog_out   = shadow[0];

    // State register.
    always_ff @(posedge prog_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        case (state)
            IDLE: begin
                if (shift_req) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (commit_req) begin
                    state_nxt = IDLE;
                end else if (shift_req && bit_cnt == CNT_FULL) begin
                    state_nxt = OVER;
                end
            end
            OVER: begin
                if (commit_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: a commit is accepted only on an exact-length frame with
    // even parity across all bits (parity bit included).
    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        if (commit_req) begin
            if (state == LOAD && bit_cnt == CNT_FULL && !(^shadow)) begin
                accept = 1'b1;
            end else begin
                reject = 1'b1;
            end
        end
    end

    // Shadow, counter and active register.
    always_ff @(posedge prog_clk) begin
        // NOTE: shadow and active are ordinary flop arrays, not RAM, so they
        // take the reset; this also discards any partially loaded frame.
        if (!rst) begin
            shadow    <= '0;
            bit_cnt   <= '0;
            active    <= '0;
            cfg_valid <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            if (shift_req) begin
                shadow <= {prog_in, shadow[CFG_BITS-1:1]};
                if (bit_cnt != CNT_OVER) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else if (commit_req) begin
                bit_cnt <= '0;
            end

            if (accept) begin
                active    <= shadow;
                cfg_valid <= 1'b1;
                cfg_error <= 1'b0;
            end else if (reject) begin
                cfg_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cb_param_block.sv
// -----------------------------------------------------------------------------
// cb_param_block
// Parametrised connection block between a CLB and a switch box. The routing
// muxes are decoded purely from the committed configuration in cb_cfg_chain,
// combinationally from the routing inputs.
//
// Ports:
//   prog_clk, rst            configuration clock, sync active-low reset
//   prog_in/prog_en          serial configuration data and shift enable
//   prog_commit              commit request
//   trk_in[W]                tracks from the neighbour side
//   trk_fb[W]                tracks fed back from the switch-box outputs
//   side_in[W]               side tracks from the neighbour
//   sb_side_out[W]           switch-box side outputs
//   clb_out                  CLB output
//   clb_in[K]                CLB inputs
//   side_out[W]              side tracks to the neighbour
//   sb_side_in[W]            switch-box side inputs
//   prog_out                 chain output to the next tile
//   cfg_valid, cfg_error     configuration status
//   bit_cnt                  bits shifted since last commit/reset
// -----------------------------------------------------------------------------
module cb_param_block
    import cb_cfg_pkg::*;
#(
    parameter  int W        = 4,
    parameter  int K        = 4,
    localparam int SEL_W    = sel_w(W),
    localparam int CFG_BITS = cfg_bits(W, K),
    localparam int CNT_W    = $clog2(CFG_BITS + 2)
) (
    input  logic             prog_clk,
    input  logic             rst,
    input  logic             prog_in,
    input  logic             prog_en,
    input  logic             prog_commit,
    input  logic [W-1:0]     trk_in,
    input  logic [W-1:0]     trk_fb,
    input  logic [W-1:0]     side_in,
    input  logic [W-1:0]     sb_side_out,
    input  logic             clb_out,
    output logic [K-1:0]     clb_in,
    output logic [W-1:0]     side_out,
    output logic [W-1:0]     sb_side_in,
    output logic             prog_out,
    output logic             cfg_valid,
    output logic             cfg_error,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [CFG_BITS-1:0] active;
    logic [2*W-1:0]      trk_mux;
    logic                unused_parity;

    cb_cfg_chain #(
        .CFG_BITS (CFG_BITS)
    ) u_chain (
        .prog_clk    (prog_clk),
        .rst         (rst),
        .prog_in     (prog_in),
        .prog_en     (prog_en),
        .prog_commit (prog_commit),
        .active      (active),
        .cfg_valid   (cfg_valid),
        .cfg_error   (cfg_error),
        .prog_out    (prog_out),
        .bit_cnt     (bit_cnt)
    );

    // The parity bit only protects the frame; routing ignores it.
    assign unused_parity = active[parity_bit(W, K)];

    for (genvar j = 0; j < W; j++) begin : g_track
        // Interleaved candidate vector for the CLB-input muxes.
        assign trk_mux[2*j]   = trk_fb[j];
        assign trk_mux[2*j+1] = trk_in[j];

        assign sb_side_in[j] = cfg_valid
                             ? (active[in_sel_bit(j)] ? side_in[j] : clb_out)
                             : 1'b0;
        assign side_out[j]   = cfg_valid
                             ? (active[out_sel_bit(j)] ? clb_out : sb_side_out[j])
                             : 1'b0;
    end

    for (genvar k = 0; k < K; k++) begin : g_clb
        logic [SEL_W-1:0] sel;
        assign sel = active[clb_sel_lsb(W, k) +: SEL_W];
        // Selects beyond the last track tie the input low.
        assign clb_in[k] = (cfg_valid && (int'(sel) < 2 * W)) ? trk_mux[sel] : 1'b0;
    end

endmodule

// File: tb/tb_cb_param_block.sv
// -----------------------------------------------------------------------------
// tb_cb_param_block
// Directed bench for cb_param_block at W=4, K=4 (21-bit frame). Expected values
// are queued when stimulus is applied and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_cb_param_block;

    localparam int W = 4;
    localparam int K = 4;

    localparam logic [31:0] FRAME_ZERO  = 32'h0;
    localparam logic [31:0] FRAME_A     = 32'h0010_0100;  // clb_in[0] sel=1, parity
    localparam logic [31:0] FRAME_B     = 32'h0010_0002;  // out-sel track0, parity
    localparam logic [31:0] FRAME_B_BAD = 32'h0000_0002;  // parity bit flipped

    logic         prog_clk;
    logic         rst;
    logic         prog_in;
    logic         prog_en;
    logic         prog_commit;
    logic [W-1:0] trk_in;
    logic [W-1:0] trk_fb;
    logic [W-1:0] side_in;
    logic [W-1:0] sb_side_out;
    logic         clb_out;
    logic [K-1:0] clb_in;
    logic [W-1:0] side_out;
    logic [W-1:0] sb_side_in;
    logic         prog_out;
    logic         cfg_valid;
    logic         cfg_error;
    logic [4:0]   bit_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    cb_param_block #(.W(W), .K(K)) dut (
        .prog_clk    (prog_clk),
        .rst         (rst),
        .prog_in     (prog_in),
        .prog_en     (prog_en),
        .prog_commit (prog_commit),
        .trk_in      (trk_in),
        .trk_fb      (trk_fb),
        .side_in     (side_in),
        .sb_side_out (sb_side_out),
        .clb_out     (clb_out),
        .clb_in      (clb_in),
        .side_out    (side_out),
        .sb_side_in  (sb_side_in),
        .prog_out    (prog_out),
        .cfg_valid   (cfg_valid),
        .cfg_error   (cfg_error),
        .bit_cnt     (bit_cnt)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            prog_in = data[i];
            prog_en = 1'b1;
            step();
        end
        prog_en = 1'b0;
        prog_in = 1'b0;
    endtask

    task automatic commit();
        prog_commit = 1'b1;
        step();
        prog_commit = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        prog_in     = 1'b0;
        prog_en     = 1'b0;
        prog_commit = 1'b0;
        trk_in      = '0;
        trk_fb      = 4'b0001;
        side_in     = 4'b1111;
        sb_side_out = 4'b1010;
        clb_out     = 1'b1;

        // Reset state: routing forced low while no configuration is valid.
        expect_val("rst_valid", 0);
        expect_val("rst_error", 0);
        expect_val("rst_cnt", 0);
        expect_val("rst_prog_out", 0);
        expect_val("rst_clb_in", 0);
        expect_val("rst_side_out", 0);
        expect_val("rst_sb_side_in", 0);
        step();
        step();
        rst = 1'b1;
        check(32'(cfg_valid));
        check(32'(cfg_error));
        check(32'(bit_cnt));
        check(32'(prog_out));
        check(32'(clb_in));
        check(32'(side_out));
        check(32'(sb_side_in));

        // All-zero frame: every CLB input selects trk_fb[0]; sides pass through.
        expect_val("zero_cnt21", 21);
        shift_bits(FRAME_ZERO, 21);
        check(32'(bit_cnt));
        expect_val("zero_valid", 1);
        expect_val("zero_error", 0);
        expect_val("zero_cnt0", 0);
        expect_val("zero_clb_in", 4'b1111);
        expect_val("zero_side_out", 4'b1010);
        expect_val("zero_sb_side_in_hi", 4'b1111);
        commit();
        check(32'(cfg_valid));
        check(32'(cfg_error));
        check(32'(bit_cnt));
        check(32'(clb_in));
        check(32'(side_out));
        check(32'(sb_side_in));
        expect_val("zero_sb_side_in_lo", 4'b0000);
        clb_out = 1'b0;
        #1;
        check(32'(sb_side_in));

        // Frame A: clb_in[0] follows trk_in[0] with zero latency.
        shift_bits(FRAME_A, 21);
        expect_val("a_valid", 1);
        expect_val("a_error", 0);
        commit();
        check(32'(cfg_valid));
        check(32'(cfg_error));
        trk_fb = 4'b0000;
        expect_val("a_trk_in1", 4'b0001);
        trk_in = 4'b0001;
        #1;
        check(32'(clb_in));
        expect_val("a_trk_in0", 4'b0000);
        trk_in = 4'b0000;
        #1;
        check(32'(clb_in));

        // Short frame (20 bits): rejected, routing keeps config A.
        expect_val("short_prog_out", 1);  // old parity bit reaches shadow[0]
        shift_bits(FRAME_ZERO, 20);
        check(32'(prog_out));
        expect_val("short_error", 1);
        expect_val("short_valid", 1);
        expect_val("short_routing", 4'b0001);
        commit();
        check(32'(cfg_error));
        check(32'(cfg_valid));
        trk_in = 4'b0001;
        #1;
        check(32'(clb_in));
        trk_in = 4'b0000;

        // Long frame: counter stops at the overlength marker.
        expect_val("long_cnt22", 22);
        shift_bits(FRAME_ZERO, 22);
        check(32'(bit_cnt));
        expect_val("long_cnt_sat", 22);
        shift_bits(FRAME_ZERO, 3);
        check(32'(bit_cnt));
        expect_val("long_error", 1);
        expect_val("long_cnt0", 0);
        commit();
        check(32'(cfg_error));
        check(32'(bit_cnt));

        // Parity error, then a good frame clears the error.
        shift_bits(FRAME_B_BAD, 21);
        expect_val("par_error", 1);
        expect_val("par_valid", 1);
        commit();
        check(32'(cfg_error));
        check(32'(cfg_valid));
        shift_bits(FRAME_A, 21);
        expect_val("par_fix_valid", 1);
        expect_val("par_fix_error", 0);
        commit();
        check(32'(cfg_valid));
        check(32'(cfg_error));

        // Reprogramming: side_out[0] holds the old routing until after commit.
        clb_out     = 1'b1;
        sb_side_out = 4'b0000;
        expect_val("reprog_mid", 4'b0000);
        shift_bits(FRAME_B, 11);
        check(32'(side_out));
        expect_val("reprog_full", 4'b0000);
        shift_bits(FRAME_B >> 11, 10);
        check(32'(side_out));
        expect_val("reprog_commit_cycle", 4'b0000);
        prog_commit = 1'b1;
        #2;
        check(32'(side_out));
        expect_val("reprog_after", 4'b0001);
        expect_val("reprog_clb_in", 4'b0000);  // config B: all selects trk_fb[0]=0
        step();
        check(32'(side_out));
        check(32'(clb_in));
        // Holding commit: the second cycle sees bit_cnt=0 and is rejected.
        expect_val("held_error", 1);
        expect_val("held_valid", 1);
        expect_val("held_routing", 4'b0001);
        step();
        prog_commit = 1'b0;
        check(32'(cfg_error));
        check(32'(cfg_valid));
        check(32'(side_out));

        // Reset mid-load discards everything.
        expect_val("mid_cnt10", 10);
        shift_bits(32'h3FF, 10);
        check(32'(bit_cnt));
        sb_side_out = 4'b1111;
        expect_val("mid_rst_cnt", 0);
        expect_val("mid_rst_valid", 0);
        expect_val("mid_rst_error", 0);
        expect_val("mid_rst_clb_in", 0);
        expect_val("mid_rst_side_out", 0);
        expect_val("mid_rst_sb_side_in", 0);
        expect_val("mid_rst_prog_out", 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check(32'(bit_cnt));
        check(32'(cfg_valid));
        check(32'(cfg_error));
        check(32'(clb_in));
        check(32'(side_out));
        check(32'(sb_side_in));
        check(32'(prog_out));

        // Commit together with shift: ignored, counter keeps going.
        shift_bits(32'h5, 3);
        expect_val("en_commit_cnt", 4);
        expect_val("en_commit_error", 0);
        expect_val("en_commit_valid", 0);
        prog_in     = 1'b1;
        prog_en     = 1'b1;
        prog_commit = 1'b1;
        step();
        prog_en     = 1'b0;
        prog_commit = 1'b0;
        check(32'(bit_cnt));
        check(32'(cfg_error));
        check(32'(cfg_valid));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_param_block.md
Name: cb_param_block

Overview:
- Parametrised connection block: W routing tracks per side, K CLB inputs.
- Holds a serial configuration chain with a shadow register, a frame bit counter, a parity check and an atomic commit into an active register.
- Routing muxes are driven from the active register only, so routing stays stable while a new frame shifts in.
- Sits between a CLB and a switch box in the tile; prog_in/prog_out daisy-chain through tiles.

Parameters:
- W, 4, tracks per side; W >= 1.
- K, 4, number of CLB inputs; K >= 1.
- SEL_W, clog2(2*W) (minimum 1), derived; width of each CLB-input select field.
- CFG_BITS, 2*W + K*SEL_W + 1, derived; frame length including the parity bit (defaults give 21).

Ports:
- prog_clk  in  1  configuration/state clock.
- rst  in  1  synchronous, active-low reset.
- prog_in  in  1  serial configuration data.
- prog_en  in  1  shift enable.
- prog_commit  in  1  commit request pulse.
- trk_in  in  W  tracks from the neighbour side.
- trk_fb  in  W  tracks fed back from the switch-box outputs.
- side_in  in  W  side tracks from the neighbour.
- sb_side_out  in  W  switch-box side outputs.
- clb_out  in  1  CLB output.
- clb_in  out  K  CLB inputs.
- side_out  out  W  side tracks to the neighbour.
- sb_side_in  out  W  switch-box side inputs.
- prog_out  out  1  serial chain output, equal to shadow[0].
- cfg_valid  out  1  active configuration is valid.
- cfg_error  out  1  last commit was rejected.
- bit_cnt  out  clog2(CFG_BITS+2)  bits shifted since the last commit or reset.

Behaviour:
- Reset (rst=0 at a prog_clk edge):
  - shadow, active and bit_cnt clear to 0; cfg_valid=0; cfg_error=0.
  - Reset mid-load discards the partial frame.
- Shift (prog_en=1):
  - shadow <= {prog_in, shadow[CFG_BITS-1:1]}.
  - bit_cnt increments, saturating at CFG_BITS+1 (overlength marker).
  - prog_out = shadow[0] combinationally from the register.
  - The first bit shifted in lands in shadow[0] after CFG_BITS shifts.
- Commit (prog_commit=1 and prog_en=0, sampled at an edge):
  - Accept when bit_cnt==CFG_BITS and the XOR of all shadow bits is 0 (even parity). Next cycle: active <= shadow, cfg_valid=1, cfg_error=0.
  - Otherwise reject. Next cycle: cfg_error=1; active and cfg_valid unchanged.
  - bit_cnt clears to 0 in both cases; shadow is retained.
- prog_commit together with prog_en=1: the commit is ignored and the shift proceeds.
- Held prog_commit: each cycle is evaluated. The second cycle sees bit_cnt=0 and is rejected.
- FSM (in the chain sub-module):
  - IDLE: bit_cnt=0.
  - LOAD: 0 < bit_cnt <= CFG_BITS.
  - OVER: bit_cnt = CFG_BITS+1.
  - prog_en moves IDLE to LOAD; LOAD moves to OVER on saturation.
  - Any commit returns to IDLE; reset returns to IDLE.
- Active-register field layout:
  - bit 2j: in-select for track j. sb_side_in[j] = bit ? side_in[j] : clb_out.
  - bit 2j+1: out-select for track j. side_out[j] = bit ? clb_out : sb_side_out[j].
  - bits [2W + k*SEL_W +: SEL_W]: select s for clb_in[k], over an interleaved vector where index 2j = trk_fb[j] and 2j+1 = trk_in[j]. If s >= 2*W, clb_in[k] = 0.
  - bit CFG_BITS-1: parity bit, not used by routing.
- While cfg_valid=0: clb_in, side_out and sb_side_in all drive 0.
- Routing outputs are combinational from the active register plus inputs; zero latency from the inputs.
- Reprogramming: outputs keep the old configuration through shifting and change only the cycle after an accepted commit.

Decomposition:
- Package cb_cfg_pkg holds:
  - functions for SEL_W, CFG_BITS and field offsets (in_sel_bit(j), out_sel_bit(j), clb_sel_lsb(k), PARITY_BIT);
  - the FSM state enum (IDLE, LOAD, OVER).
- Sub-module cb_cfg_chain (parameter CFG_BITS) holds shadow, bit_cnt, FSM, parity check and the active register. It outputs active, cfg_valid, cfg_error and prog_out.
- The top level contains only the generate-loop routing muxes.

Test Plan (defaults W=4, K=4, CFG_BITS=21):
- Reset, then shift 21 zeros, then commit -> cfg_valid=1, cfg_error=0, bit_cnt=0. With trk_fb=4'b0001: clb_in=4'b1111. side_out=sb_side_out; sb_side_in={4{clb_out}}.
- Frame with bit 8=1 (clb_in[0] select=1) and parity bit 20=1 -> after commit, clb_in[0] follows trk_in[0]. Toggle trk_in=4'b0001 and 4'b0000: clb_in[0] toggles 1/0 with zero latency.
- Shift 20 bits then commit -> cfg_error=1, cfg_valid unchanged, routing unchanged. Shift 22 bits then commit -> bit_cnt=22 before commit, then cfg_error=1.
- Valid 21-bit frame with the parity bit flipped -> rejected, cfg_error=1. A following correct frame -> cfg_valid=1, cfg_error=0.
- Committed config A, then shift config B with out-select bit 1=1 -> side_out[0] stays sb_side_out[0] until the cycle after commit, then equals clb_out.
- Assert rst=0 after 10 shifts -> bit_cnt=0, cfg_valid=0, all routing outputs 0, prog_out=0. Commit with prog_en=1 -> ignored, bit_cnt keeps incrementing.
